id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
The ID/EX pipeline register and operand-select logic that feeds the 32-bit ALU, which is built from ALU bit slices. It captures decoded instruction fields each cycle and decodes ALUOp/funct into the slice Op, Binvert and LSB carry-in. It forwards results from EX/MEM and MEM/WB, and presents ALU operands, store data and downstream control to the EX stage.

Parameters:
W, 32, datapath width (register values, immediate, ALU operands)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all pipeline registers (load-use bubble upstream)
flush  in  1  replace captured instruction with bubble (branch taken)
id_valid  in  1  ID stage holds a real instruction
id_ctrl  in  8  [7]regwrite [6]memread [5]memwrite [4]memtoreg [3]regdst [2]alusrc [1:0]aluop
id_funct  in  6  R-type funct field
id_rs_data  in  W  register-file read port 1
id_rt_data  in  W  register-file read port 2
id_imm  in  W  sign-extended immediate
id_rs  in  5  rs number
id_rt  in  5  rt number
id_rd  in  5  rd number
exm_regwrite  in  1  EX/MEM writes a register
exm_rd  in  5  EX/MEM destination
exm_result  in  W  EX/MEM ALU result
mwb_regwrite  in  1  MEM/WB writes a register
mwb_rd  in  5  MEM/WB destination
mwb_data  in  W  MEM/WB writeback data
alu_a  out  W  ALU operand A
alu_b  out  W  ALU operand B before slice inversion
alu_op  out  3  slice Op: AND 000, OR 001, ADD 010, SUB 110, SLT 111
alu_binvert  out  1  Binvert to every slice
alu_cin  out  1  carry-in to bit 0
store_data  out  W  forwarded rt value for sw
ex_dest  out  5  destination: rd if regdst else rt
ex_ctrl  out  4  registered {regwrite, memread, memwrite, memtoreg}
ex_valid  out  1  EX holds a real instruction
illegal  out  1  registered R-type with unsupported funct

Behaviour:
- Async reset (rst_n=0): all registers clear immediately. ex_valid=0, ex_ctrl=0, ex_dest=0, illegal=0. Stored data/imm/numbers are 0, so alu_a=alu_b=store_data=0 unless forwarding matches. alu_op=010, alu_binvert=0, alu_cin=0.
- Per edge, priority flush > stall > load:
  - Flush: ex_valid=0, ex_ctrl=0, illegal=0; data fields don't-care, held.
  - Stall: every register holds.
  - Otherwise capture all id_* fields. ex_valid=id_valid. ex_ctrl is forced 0 when id_valid=0.
- A simultaneous stall and flush produces a bubble.
- ALU decode is registered; alu_op is valid one cycle after capture:
  - aluop 00 gives ADD (lw/sw). aluop 01 gives SUB (beq). aluop 11 gives OR (ori).
  - aluop 10 decodes funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - Any other funct gives ADD with illegal=1.
- alu_binvert = alu_cin = alu_op[2], so SUB and SLT perform A+~B+1.
- Forwarding is combinational from the registered rs/rt and the current exm_*/mwb_* inputs:
  - Source A: if exm_regwrite and exm_rd!=0 and exm_rd==rs, use exm_result. Else if mwb_regwrite and mwb_rd!=0 and mwb_rd==rs, use mwb_data. Else use the stored rs_data.
  - EX/MEM wins when both match. The same rules apply to rt for source B.
- alu_b = imm when alusrc=1, else forwarded rt. store_data is always forwarded rt.
- Register $0 is never forwarded. Reading $0 yields the stored value, which the register file guarantees is 0.
- Bubbles (ex_valid=0) still drive operands. Downstream ignores them through ex_ctrl=0.

Test Plan:
1. Reset mid-run, rst_n low between edges -> ex_valid, ex_ctrl, illegal = 0 at once. After release, the first captured add drives alu_op=010 on the next cycle.
2. R-type sub, rs=3(10), rt=4(3) -> alu_op=110, binvert=1, cin=1, alu_a=10, alu_b=3. funct 0x2A -> 111. funct 0x27 -> 010 with illegal=1.
3. exm_rd=3 (0x55) and mwb_rd=3 (0x77) both writing, instruction rs=3 -> alu_a=0x55. Drop exm_regwrite -> 0x77. Set exm_rd=0 with rs=0 -> stored value.
4. lw aluop 00, alusrc=1, imm=0xFFFFFFFC -> alu_b=0xFFFFFFFC, alu_op=010. sw with rt forwarded from MEM/WB 0x1234 -> store_data=0x1234, alu_b=imm.
5. stall held 2 cycles with changing id_* -> outputs frozen. Then flush with stall still high -> ex_valid=0, ex_ctrl=0.
6. regdst=1, rd=9, rt=5 -> ex_dest=9. regdst=0 -> ex_dest=5. id_valid=0 with id_ctrl=0xFF -> ex_ctrl=0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU-slice control decode and EX/MEM, MEM/WB
// operand forwarding. Operand and forwarding paths are combinational from the
// registered fields, so the EX stage sees them in the cycle after capture.
module id_ex_operand_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  logic [7:0]   id_ctrl,
  input  logic [5:0]   id_funct,
  input  logic [W-1:0] id_rs_data,
  input  logic [W-1:0] id_rt_data,
  input  logic [W-1:0] id_imm,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic [4:0]   id_rd,
  input  logic         exm_regwrite,
  input  logic [4:0]   exm_rd,
  input  logic [W-1:0] exm_result,
  input  logic         mwb_regwrite,
  input  logic [4:0]   mwb_rd,
  input  logic [W-1:0] mwb_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_binvert,
  output logic         alu_cin,
  output logic [W-1:0] store_data,
  output logic [4:0]   ex_dest,
  output logic [3:0]   ex_ctrl,
  output logic         ex_valid,
  output logic         illegal
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic         valid_q,   valid_d;
  logic [3:0]   ctrl_q,    ctrl_d;
  logic         illegal_q, illegal_d;
  logic [2:0]   op_q,      op_d;
  logic         alusrc_q,  alusrc_d;
  logic [4:0]   dest_q,    dest_d;
  logic [4:0]   rs_q,      rs_d;
  logic [4:0]   rt_q,      rt_d;
  logic [W-1:0] rs_data_q, rs_data_d;
  logic [W-1:0] rt_data_q, rt_data_d;
  logic [W-1:0] imm_q,     imm_d;

  logic [2:0]   dec_op;
  logic         dec_illegal;
  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;

  // Decode ALUOp/funct into the slice Op; unknown R-type funct falls back to ADD
  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    unique case (id_ctrl[1:0])
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b11: dec_op = OP_OR;
      2'b10: begin
        case (id_funct)
          6'h20:   dec_op = OP_ADD;
          6'h22:   dec_op = OP_SUB;
          6'h24:   dec_op = OP_AND;
          6'h25:   dec_op = OP_OR;
          6'h2A:   dec_op = OP_SLT;
          default: begin
            dec_op      = OP_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: dec_op = OP_ADD;
    endcase
  end

  // Next-state selection: flush beats stall beats load; flush leaves data fields held
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    op_d      = op_q;
    alusrc_d  = alusrc_q;
    dest_d    = dest_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    if (flush) begin
      valid_d   = 1'b0;
      ctrl_d    = 4'b0000;
      illegal_d = 1'b0;
    end else if (!stall) begin
      valid_d   = id_valid;
      // A non-instruction must never write registers or memory downstream
      ctrl_d    = id_valid ? id_ctrl[7:4] : 4'b0000;
      illegal_d = dec_illegal & id_valid;
      op_d      = dec_op;
      alusrc_d  = id_ctrl[2];
      dest_d    = id_ctrl[3] ? id_rd : id_rt;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
    end
  end

  // Pipeline register bank; reset Op is ADD so an idle ALU does no subtract
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= 4'b0000;
      illegal_q <= 1'b0;
      op_q      <= OP_ADD;
      alusrc_q  <= 1'b0;
      dest_q    <= 5'd0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      op_q      <= op_d;
      alusrc_q  <= alusrc_d;
      dest_q    <= dest_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  // Forwarding: youngest producer (EX/MEM) wins; $0 is never forwarded
  always_comb begin
    fwd_a = rs_data_q;
    if (exm_regwrite && (exm_rd != 5'd0) && (exm_rd == rs_q)) begin
      fwd_a = exm_result;
    end else if (mwb_regwrite && (mwb_rd != 5'd0) && (mwb_rd == rs_q)) begin
      fwd_a = mwb_data;
    end
    fwd_b = rt_data_q;
    if (exm_regwrite && (exm_rd != 5'd0) && (exm_rd == rt_q)) begin
      fwd_b = exm_result;
    end else if (mwb_regwrite && (mwb_rd != 5'd0) && (mwb_rd == rt_q)) begin
      fwd_b = mwb_data;
    end
  end

  assign alu_a       = fwd_a;
  assign alu_b       = alusrc_q ? imm_q : fwd_b;
  assign store_data  = fwd_b;
  assign alu_op      = op_q;
  // SUB and SLT need A + ~B + 1: invert B in every slice and carry 1 into bit 0
  assign alu_binvert = op_q[2];
  assign alu_cin     = op_q[2];
  assign ex_dest     = dest_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_valid    = valid_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: each task drives one scenario and
// compares outputs against hand-computed values one time unit after the edge.
module tb_id_ex_operand_stage;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic         flush;
  logic         id_valid;
  logic [7:0]   id_ctrl;
  logic [5:0]   id_funct;
  logic [W-1:0] id_rs_data;
  logic [W-1:0] id_rt_data;
  logic [W-1:0] id_imm;
  logic [4:0]   id_rs;
  logic [4:0]   id_rt;
  logic [4:0]   id_rd;
  logic         exm_regwrite;
  logic [4:0]   exm_rd;
  logic [W-1:0] exm_result;
  logic         mwb_regwrite;
  logic [4:0]   mwb_rd;
  logic [W-1:0] mwb_data;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic         alu_binvert;
  logic         alu_cin;
  logic [W-1:0] store_data;
  logic [4:0]   ex_dest;
  logic [3:0]   ex_ctrl;
  logic         ex_valid;
  logic         illegal;

  int total;
  int bad;

  id_ex_operand_stage #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_binvert(alu_binvert),
    .alu_cin(alu_cin), .store_data(store_data), .ex_dest(ex_dest),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [7:0] c, input logic [5:0] f,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [W-1:0] rsd, input logic [W-1:0] rtd,
                          input logic [W-1:0] imm);
    id_valid   = v;
    id_ctrl    = c;
    id_funct   = f;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_rs_data = rsd;
    id_rt_data = rtd;
    id_imm     = imm;
  endtask

  task automatic fwd_off();
    exm_regwrite = 1'b0;
    exm_rd       = 5'd0;
    exm_result   = '0;
    mwb_regwrite = 1'b0;
    mwb_rd       = 5'd0;
    mwb_data     = '0;
  endtask

  task automatic test_reset();
    // R-type sub first so the reset visibly returns alu_op to ADD
    drive_id(1'b1, 8'h8A, 6'h22, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0);
    step();
    #2 rst_n = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", ex_valid); end
    total++; if (ex_ctrl !== 4'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", ex_ctrl); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b want=0", illegal); end
    total++; if (alu_op !== 3'b010 || alu_binvert !== 1'b0 || alu_cin !== 1'b0) begin
      bad++; $display("FAIL reset_op got=%b/%0b/%0b want=010/0/0", alu_op, alu_binvert, alu_cin); end
    total++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || store_data !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", alu_a, alu_b, store_data); end
    #1 rst_n = 1'b1;
    drive_id(1'b1, 8'h8A, 6'h20, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0);
    step();
    total++; if (alu_op !== 3'b010 || ex_valid !== 1'b1) begin
      bad++; $display("FAIL reset_first_add got=%b/%0b want=010/1", alu_op, ex_valid); end
  endtask

  task automatic test_rtype();
    logic [7:0] ctl [4];
    logic [2:0] exp [4];
    drive_id(1'b1, 8'h8A, 6'h22, 5'd3, 5'd4, 5'd7, 32'd10, 32'd3, 32'h0);
    step();
    total++; if (alu_op !== 3'b110 || alu_binvert !== 1'b1 || alu_cin !== 1'b1) begin
      bad++; $display("FAIL sub_op got=%b/%0b/%0b want=110/1/1", alu_op, alu_binvert, alu_cin); end
    total++; if (alu_a !== 32'd10 || alu_b !== 32'd3) begin
      bad++; $display("FAIL sub_operands got=%0d/%0d want=10/3", alu_a, alu_b); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL sub_illegal got=%0b want=0", illegal); end
    id_funct = 6'h2A;
    step();
    total++; if (alu_op !== 3'b111 || alu_binvert !== 1'b1) begin
      bad++; $display("FAIL slt_op got=%b/%0b want=111/1", alu_op, alu_binvert); end
    id_funct = 6'h24;
    step();
    total++; if (alu_op !== 3'b000 || alu_binvert !== 1'b0) begin
      bad++; $display("FAIL and_op got=%b/%0b want=000/0", alu_op, alu_binvert); end
    id_funct = 6'h27;
    step();
    total++; if (alu_op !== 3'b010 || illegal !== 1'b1) begin
      bad++; $display("FAIL nor_illegal got=%b/%0b want=010/1", alu_op, illegal); end
    // beq, ori, add funct 0x25 (or), lw-style aluop 00 with junk funct
    ctl[0] = 8'h01; exp[0] = 3'b110;
    ctl[1] = 8'h87; exp[1] = 3'b001;
    ctl[2] = 8'h8A; exp[2] = 3'b001;
    ctl[3] = 8'h00; exp[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      id_ctrl  = ctl[i];
      id_funct = (i == 2) ? 6'h25 : 6'h3F;
      step();
      total++; if (alu_op !== exp[i] || illegal !== 1'b0) begin
        bad++; $display("FAIL aluop_vec%0d got=%b/%0b want=%b/0", i, alu_op, illegal, exp[i]); end
    end
  endtask

  task automatic test_forward();
    drive_id(1'b1, 8'h8A, 6'h20, 5'd3, 5'd3, 5'd8, 32'h11, 32'h22, 32'h0);
    exm_regwrite = 1'b1; exm_rd = 5'd3; exm_result = 32'h55;
    mwb_regwrite = 1'b1; mwb_rd = 5'd3; mwb_data   = 32'h77;
    step();
    total++; if (alu_a !== 32'h55) begin bad++; $display("FAIL fwd_exm_a got=%h want=55", alu_a); end
    total++; if (alu_b !== 32'h55) begin bad++; $display("FAIL fwd_exm_b got=%h want=55", alu_b); end
    exm_regwrite = 1'b0;
    #1;
    total++; if (alu_a !== 32'h77) begin bad++; $display("FAIL fwd_mwb_a got=%h want=77", alu_a); end
    mwb_regwrite = 1'b0;
    #1;
    total++; if (alu_a !== 32'h11 || alu_b !== 32'h22) begin
      bad++; $display("FAIL fwd_none got=%h/%h want=11/22", alu_a, alu_b); end
    drive_id(1'b1, 8'h8A, 6'h20, 5'd0, 5'd0, 5'd8, 32'hABCD, 32'h0, 32'h0);
    exm_regwrite = 1'b1; exm_rd = 5'd0; exm_result = 32'h55;
    mwb_regwrite = 1'b1; mwb_rd = 5'd0; mwb_data   = 32'h77;
    step();
    total++; if (alu_a !== 32'hABCD) begin bad++; $display("FAIL fwd_r0 got=%h want=abcd", alu_a); end
    fwd_off();
  endtask

  task automatic test_mem();
    drive_id(1'b1, 8'hD4, 6'h00, 5'd2, 5'd5, 5'd0, 32'h100, 32'h9, 32'hFFFFFFFC);
    step();
    total++; if (alu_b !== 32'hFFFFFFFC || alu_op !== 3'b010) begin
      bad++; $display("FAIL lw_operand got=%h/%b want=fffffffc/010", alu_b, alu_op); end
    total++; if (ex_ctrl !== 4'b1101 || ex_dest !== 5'd5) begin
      bad++; $display("FAIL lw_ctrl got=%b/%0d want=1101/5", ex_ctrl, ex_dest); end
    drive_id(1'b1, 8'h24, 6'h00, 5'd2, 5'd6, 5'd0, 32'h100, 32'h0, 32'h10);
    mwb_regwrite = 1'b1; mwb_rd = 5'd6; mwb_data = 32'h1234;
    step();
    total++; if (store_data !== 32'h1234) begin bad++; $display("FAIL sw_store got=%h want=1234", store_data); end
    total++; if (alu_b !== 32'h10 || ex_ctrl !== 4'b0010) begin
      bad++; $display("FAIL sw_alub got=%h/%b want=10/0010", alu_b, ex_ctrl); end
    fwd_off();
  endtask

  task automatic test_stall_flush();
    drive_id(1'b1, 8'h24, 6'h00, 5'd2, 5'd6, 5'd0, 32'h100, 32'h66, 32'h10);
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_id(1'b1, 8'h8A, 6'h22, 5'd9 + 5'(i), 5'd10, 5'd11, 32'h999 + W'(i), 32'h888, 32'h44);
      step();
      total++; if (ex_valid !== 1'b1 || ex_ctrl !== 4'b0010 || alu_op !== 3'b010 ||
                   alu_b !== 32'h10 || alu_a !== 32'h100 || store_data !== 32'h66) begin
        bad++; $display("FAIL stall_hold%0d got=%0b/%b/%b/%h/%h/%h", i, ex_valid, ex_ctrl, alu_op, alu_b, alu_a, store_data); end
    end
    flush = 1'b1;
    step();
    total++; if (ex_valid !== 1'b0 || ex_ctrl !== 4'b0000 || illegal !== 1'b0) begin
      bad++; $display("FAIL stall_flush got=%0b/%b/%0b want=0/0000/0", ex_valid, ex_ctrl, illegal); end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_dest();
    drive_id(1'b1, 8'h8A, 6'h20, 5'd1, 5'd5, 5'd9, 32'h1, 32'h2, 32'h0);
    step();
    total++; if (ex_dest !== 5'd9) begin bad++; $display("FAIL dest_rd got=%0d want=9", ex_dest); end
    id_ctrl = 8'h82;
    step();
    total++; if (ex_dest !== 5'd5) begin bad++; $display("FAIL dest_rt got=%0d want=5", ex_dest); end
    drive_id(1'b0, 8'hFF, 6'h20, 5'd1, 5'd5, 5'd9, 32'h1, 32'h2, 32'h0);
    step();
    total++; if (ex_ctrl !== 4'b0000 || ex_valid !== 1'b0) begin
      bad++; $display("FAIL bubble_ctrl got=%b/%0b want=0000/0", ex_ctrl, ex_valid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive_id(1'b0, 8'h00, 6'h00, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    fwd_off();
    #12 rst_n = 1'b1;
    #1;
    test_reset();
    test_rtype();
    test_forward();
    test_mem();
    test_stall_flush();
    test_dest();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
